// File: rtl/xor_cosim_stimgen.sv
// Stimulus generator for the XOR-gate cosim: an exhaustive sweep of the low input
// bits followed by a fixed-length LFSR run, streamed over valid/ready with an index.
module xor_cosim_stimgen #(
  parameter int unsigned EXH_BITS = 5,
  parameter int unsigned NRAND    = 64,
  parameter logic [31:0] SEED     = 32'h1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_vec,
  output logic [16:0]  out_idx,
  output logic         busy,
  output logic         done
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [31:0]         SeedEff  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0]         LfsrMask = 32'h8020_0003;
  localparam logic [15:0]         RandLast = (NRAND == 0) ? 16'h0 : 16'(NRAND - 1);
  localparam logic [EXH_BITS-1:0] ExhLast  = '1;
  localparam bit                  HasRand  = (NRAND > 0);

  typedef enum logic [1:0] {StIdle, StExh, StRand} state_e;

  state_e              state_q, state_d;
  logic [EXH_BITS-1:0] cnt_q, cnt_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic [15:0]         rcnt_q, rcnt_d;
  logic [16:0]         idx_q, idx_d;
  logic                done_q, done_d;
  logic                xfer;

  function automatic logic [31:0] bit_rev(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LfsrMask : 32'h0);
  endfunction

  assign xfer = (state_q != StIdle) && out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    rcnt_d  = rcnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StExh;
          cnt_d   = '0;
          lfsr_d  = SeedEff;
          rcnt_d  = '0;
          idx_d   = '0;
        end
      end
      StExh: begin
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          idx_d = idx_q + 17'd1;
          if (cnt_q == ExhLast) begin
            if (HasRand) begin
              state_d = StRand;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
      end
      StRand: begin
        if (xfer) begin
          lfsr_d = lfsr_step(lfsr_q);
          rcnt_d = rcnt_q + 16'd1;
          idx_d  = idx_q + 17'd1;
          if (rcnt_q == RandLast) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lfsr_q  <= SeedEff;
      rcnt_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      rcnt_q  <= rcnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Outputs decode registered state only; nothing flows through from start/out_ready.
  always_comb begin
    out_vec = '0;
    case (state_q)
      StExh:   out_vec[EXH_BITS-1:0] = cnt_q;
      StRand:  out_vec = {lfsr_q, bit_rev(lfsr_q), ~lfsr_q, lfsr_q ^ 32'hA5A5_A5A5};
      default: out_vec = '0;
    endcase
  end

  assign busy      = (state_q != StIdle);
  assign out_valid = busy;
  assign out_idx   = busy ? idx_q : 17'd0;
  assign done      = done_q;

endmodule

// File: tb/tb_xor_cosim_stimgen.sv
// Directed bench: default-parameter stream, backpressure, mid-run reset, held start,
// plus small instances for a sweep-only run and a zero seed.
module tb_xor_cosim_stimgen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start1, ready1, valid1, busy1, done1;
  logic start2, ready2, valid2, busy2, done2;
  logic start3, ready3, valid3, busy3, done3;
  logic [127:0] vec1, vec2, vec3;
  logic [16:0]  idx1, idx2, idx3;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] FirstRand = 128'h00000001_80000000_FFFFFFFE_A5A5A5A4;

  xor_cosim_stimgen dut1 (
    .clk(clk), .rst(rst), .start(start1), .out_valid(valid1), .out_ready(ready1),
    .out_vec(vec1), .out_idx(idx1), .busy(busy1), .done(done1)
  );

  xor_cosim_stimgen #(.EXH_BITS(2), .NRAND(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .out_valid(valid2), .out_ready(ready2),
    .out_vec(vec2), .out_idx(idx2), .busy(busy2), .done(done2)
  );

  xor_cosim_stimgen #(.EXH_BITS(1), .NRAND(2), .SEED(32'h0)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .out_valid(valid3), .out_ready(ready3),
    .out_vec(vec3), .out_idx(idx3), .busy(busy3), .done(done3)
  );

  // Expected vector for a given index, straight from the sweep/LFSR definition.
  function automatic logic [127:0] model_vec(input int idx, input int exh, input logic [31:0] seed);
    logic [31:0] l;
    logic [31:0] r;
    if (idx < (1 << exh)) return 128'(idx);
    l = (seed == 32'h0) ? 32'h1 : seed;
    for (int k = 0; k < idx - (1 << exh); k++) begin
      l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
    end
    for (int b = 0; b < 32; b++) r[b] = l[31-b];
    return {l, r, ~l, l ^ 32'hA5A5_A5A5};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start1 = 0; start2 = 0; start3 = 0;
    ready1 = 0; ready2 = 0; ready3 = 0;
    tick();
    tick();
    tests++;
    if (valid1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got valid=%b busy=%b done=%b want 0 0 0", valid1, busy1, done1);
    end
    tests++;
    if (vec1 !== 128'h0 || idx1 !== 17'h0) begin
      fails++;
      $display("FAIL reset_data: got vec=%h idx=%0d want 0 0", vec1, idx1);
    end
    tests++;
    if (valid2 !== 1'b0 || valid3 !== 1'b0) begin
      fails++;
      $display("FAIL reset_small: got valid2=%b valid3=%b want 0 0", valid2, valid3);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    int n = 0;
    int done_at = -1;
    int done_cnt = 0;
    ready1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tests++;
    if (valid1 !== 1'b1 || idx1 !== 17'd0 || vec1 !== 128'h0) begin
      fails++;
      $display("FAIL stream_first: got valid=%b idx=%0d vec=%h want 1 0 0", valid1, idx1, vec1);
    end
    for (int c = 1; c <= 200 && done_at < 0; c++) begin
      if (valid1) begin
        tests++;
        if (idx1 !== 17'(n) || vec1 !== model_vec(n, 5, 32'h1)) begin
          fails++;
          $display("FAIL stream_vec: got idx=%0d vec=%h want idx=%0d vec=%h",
                   idx1, vec1, n, model_vec(n, 5, 32'h1));
        end
        if (n == 32) begin
          tests++;
          if (vec1 !== FirstRand) begin
            fails++;
            $display("FAIL stream_idx32: got %h want %h", vec1, FirstRand);
          end
        end
        if (n == 33) begin
          tests++;
          if (vec1[127:96] !== 32'h8020_0003) begin
            fails++;
            $display("FAIL stream_idx33: got lfsr=%h want 80200003", vec1[127:96]);
          end
        end
        n++;
      end
      tick();
      if (done1) begin
        done_at = c;
        done_cnt++;
      end
    end
    tests++;
    if (n != 96) begin
      fails++;
      $display("FAIL stream_count: got %0d transfers want 96", n);
    end
    // Done is visible 96 edges after the start edge (97 cycles counting the start cycle).
    tests++;
    if (done_at != 96) begin
      fails++;
      $display("FAIL stream_done_time: got %0d want 96", done_at);
    end
    tests++;
    if (valid1 !== 1'b0 || busy1 !== 1'b0) begin
      fails++;
      $display("FAIL stream_idle_at_done: got valid=%b busy=%b want 0 0", valid1, busy1);
    end
    tick();
    tests++;
    if (done1 !== 1'b0 || done_cnt != 1) begin
      fails++;
      $display("FAIL stream_done_pulse: got done=%b pulses=%0d want 0 1", done1, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int stall = 0;
    bit seen_done = 0;
    ready1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 0; c < 400 && !seen_done; c++) begin
      if (valid1) begin
        if (idx1 == 17'd7 && stall < 5) begin
          ready1 = 1'b0;
          stall++;
          tests++;
          if (vec1 !== 128'd7 || idx1 !== 17'd7) begin
            fails++;
            $display("FAIL bp_stall_hold: got vec=%h idx=%0d want 7 7", vec1, idx1);
          end
        end else begin
          ready1 = c[0];
        end
        if (ready1) begin
          tests++;
          if (idx1 !== 17'(n) || vec1 !== model_vec(n, 5, 32'h1)) begin
            fails++;
            $display("FAIL bp_vec: got idx=%0d vec=%h want idx=%0d vec=%h",
                     idx1, vec1, n, model_vec(n, 5, 32'h1));
          end
          n++;
        end
      end
      tick();
      if (done1) seen_done = 1;
    end
    tests++;
    if (n != 96 || !seen_done || stall != 5) begin
      fails++;
      $display("FAIL bp_total: got n=%0d done=%0b stall=%0d want 96 1 5", n, seen_done, stall);
    end
    ready1 = 1'b0;
    tick();
  endtask

  task automatic test_rst_mid();
    bit saw_done = 0;
    ready1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 0; c < 100 && idx1 != 17'd40; c++) tick();
    tests++;
    if (idx1 !== 17'd40) begin
      fails++;
      $display("FAIL rst_reach40: got idx=%0d want 40", idx1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (valid1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0 || vec1 !== 128'h0 || idx1 !== 17'h0) begin
      fails++;
      $display("FAIL rst_mid_clear: got valid=%b busy=%b done=%b vec=%h idx=%0d want all 0",
               valid1, busy1, done1, vec1, idx1);
    end
    for (int c = 0; c < 100; c++) begin
      tick();
      if (done1) saw_done = 1;
    end
    tests++;
    if (saw_done || valid1 !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_nodone: got done_seen=%0b valid=%b want 0 0", saw_done, valid1);
    end
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tests++;
    if (valid1 !== 1'b1 || idx1 !== 17'd0 || vec1 !== 128'h0) begin
      fails++;
      $display("FAIL rst_restart: got valid=%b idx=%0d vec=%h want 1 0 0", valid1, idx1, vec1);
    end
    do_reset();
  endtask

  task automatic test_start_held();
    int n = 0;
    bit seen_done = 0;
    ready1 = 1'b1;
    start1 = 1'b1;
    tick();
    for (int c = 0; c < 200 && !seen_done; c++) begin
      if (valid1) begin
        tests++;
        if (idx1 !== 17'(n)) begin
          fails++;
          $display("FAIL held_idx: got %0d want %0d", idx1, n);
        end
        n++;
      end
      tick();
      if (done1) seen_done = 1;
    end
    tests++;
    if (!seen_done || n != 96 || valid1 !== 1'b0) begin
      fails++;
      $display("FAIL held_done: got done=%0b n=%0d valid=%b want 1 96 0", seen_done, n, valid1);
    end
    tick();
    tests++;
    if (valid1 !== 1'b1 || idx1 !== 17'd0 || vec1 !== 128'h0) begin
      fails++;
      $display("FAIL held_restart: got valid=%b idx=%0d vec=%h want 1 0 0", valid1, idx1, vec1);
    end
    start1 = 1'b0;
    do_reset();
  endtask

  task automatic test_exh_only();
    int n = 0;
    bit seen_done = 0;
    ready2 = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      if (valid2) begin
        tests++;
        if (vec2 !== 128'(n) || idx2 !== 17'(n)) begin
          fails++;
          $display("FAIL exh_vec: got vec=%h idx=%0d want %0d", vec2, idx2, n);
        end
        n++;
      end
      tick();
      if (done2) seen_done = 1;
    end
    tests++;
    if (n != 4 || !seen_done || valid2 !== 1'b0) begin
      fails++;
      $display("FAIL exh_total: got n=%0d done=%0b valid=%b want 4 1 0", n, seen_done, valid2);
    end
  endtask

  task automatic test_seed_zero();
    int n = 0;
    bit seen_done = 0;
    ready3 = 1'b1;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      if (valid3) begin
        if (n == 2) begin
          tests++;
          if (vec3 !== FirstRand) begin
            fails++;
            $display("FAIL seed0_first: got %h want %h", vec3, FirstRand);
          end
        end
        if (n == 3) begin
          tests++;
          if (vec3[127:96] !== 32'h8020_0003) begin
            fails++;
            $display("FAIL seed0_second: got lfsr=%h want 80200003", vec3[127:96]);
          end
        end
        n++;
      end
      tick();
      if (done3) seen_done = 1;
    end
    tests++;
    if (n != 4 || !seen_done) begin
      fails++;
      $display("FAIL seed0_total: got n=%0d done=%0b want 4 1", n, seen_done);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_rst_mid();
    test_start_held();
    test_exh_only();
    test_seed_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
